pc_next_unit: RTL and testbench
===============================

# pc_next_unit

Program-counter and next-address stage for the single-issue processor. It consumes the 11-bit control word from the opcode decoder together with ALU comparison flags and instruction immediates. It holds the architectural PC and computes the next fetch address for the synchronous instruction memory. It also provides the PC+1 link value that the register-writeback mux selects for `jal`.

## Interface
Parameters:
- `PC_W`, default 12: PC and imem address width.
- `CNT_W`, default 32: retired-instruction counter width.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `ctrl_sig`, in, 11: decoder control word. Bit order is [10] BRlt, [9] ALUfunc, [8] Rwd2, [7] Rwe, [6] Rsrc2, [5] ALUinB, [4] ALUop, [3] DMwe, [2] Rwd, [1] BRne, [0] JP. Only bits 10, 1 and 0 are used here.
- `alu_ne`, in, 1: ALU operands not equal.
- `alu_lt`, in, 1: ALU blt condition true.
- `imm`, in, 17: instruction immediate N, two's complement.
- `target`, in, 27: jump target T.
- `stall`, in, 1: freeze the PC for this cycle.
- `pc`, out, PC_W: address of the instruction currently executing.
- `pc_plus1`, out, PC_W: pc+1 modulo 2^PC_W (jal link).
- `imem_addr`, out, PC_W: address presented to the synchronous imem.
- `instr_valid`, out, 1: the imem output corresponds to `pc`.
- `branch_taken`, out, 1: redirect (jump or taken branch) this cycle.
- `retired`, out, CNT_W: count of committed instructions.

## Operation
- Redirect selection applies in priority order:
  - JP=1: next = target[PC_W-1:0], and `branch_taken`=1.
  - Else if (BRne & alu_ne) or (BRlt & alu_lt): next = pc + 1 + sext(imm), truncated to PC_W. `branch_taken`=1.
  - Else: next = pc + 1.
- If JP and a branch bit are both set, JP wins. The decoder never produces this combination, but the block must still handle it deterministically.
- All PC arithmetic is modulo 2^PC_W:
  - pc = all-ones with no redirect gives next = 0.
  - A negative imm wraps below 0 the same way.
- Upper target bits [26:PC_W] are ignored.
- `stall`=1 holds `pc` and `retired`. In that cycle, `imem_addr` = pc (refetch) and `branch_taken` = 0.
- Warm-up state:
  - `instr_valid`=0 in the first cycle after reset release.
  - In that cycle `pc` holds 0, `imem_addr`=0, `branch_taken`=0, and `retired` does not count.
  - `instr_valid` becomes 1 at the next edge and stays 1 until reset.
  - This guarantees that the imem has sampled address 0 at least once, whether or not any clock edge occurred during reset.
- `retired` increments by 1 on every edge where instr_valid=1 and stall=0. It wraps at 2^CNT_W.

## Timing
- Reset values, applied asynchronously: `pc`=0, `pc_plus1`=1, `imem_addr`=0, `instr_valid`=0, `branch_taken`=0, `retired`=0.
- `imem_addr` is combinational and equals the next-PC value. The imem registers it on the same edge that loads `pc`, so the instruction for `pc` is present throughout the following cycle. Effective fetch latency is therefore zero bubbles, including on a redirect.
- `branch_taken` and `pc_plus1` are combinational from the current cycle's inputs and `pc`.
- Reset asserted mid-operation clears all state immediately, and warm-up repeats after release.
- When stall and redirect occur simultaneously, the stall wins and the redirect is not lost. The upstream inputs are held during a stall, so the redirect is taken on the first unstalled cycle.

## Structure
- Shared processor package:
  - Control-word bit-index constants (CTRL_BRLT=10 … CTRL_JP=0).
  - Opcode constants.
  - `PC_W`.
- One natural sub-module, `pc_adder`: a PC_W-bit adder computing pc+1 and pc+1+sext(imm), with explicit truncation.
- The state is three registers:
  - `pc`
  - the `instr_valid` warm-up flag (a two-state machine, WARMUP then RUN)
  - the `retired` counter.

## Test plan
- Reset release with no stall and all ctrl bits 0: cycle 0 has instr_valid=0 and imem_addr=0. After that, pc steps 0,1,2,3, and retired=3 after four valid cycles.
- Jump from pc=5 with ctrl_sig=11'h001 and target=27'h0000123: imem_addr=12'h123, branch_taken=1, and pc=12'h123 next cycle.
- Branches from pc=10:
  - bne with ctrl_sig=11'h052, alu_ne=1, imm=-3: next pc=8.
  - The same case with alu_ne=0: next pc=11 and branch_taken=0.
- blt (ctrl_sig=11'h450) with alu_lt=1 and imm=17'h0FFFF at pc=12'hFF0: pc wraps modulo 4096 to 12'hFF0+1+65535 mod 4096 = 12'hFF0.
- stall=1 for 3 cycles at pc=7 while jal (ctrl_sig=11'h181) targets 40: pc, pc_plus1=8 and retired are frozen, imem_addr=7, and branch_taken=0. The cycle after stall drops, pc=40.
- Assert reset asynchronously mid-cycle while pc=12'h2A: outputs go to their reset values without waiting for a clock edge, and the warm-up cycle repeats.

Source files
------------

// File: rtl/pc_next_unit_pkg.sv
// ============================================================================
// pc_next_unit_pkg : shared processor constants (control word, opcodes, widths)
// Revision 1.0
// ============================================================================
`default_nettype none

package pc_next_unit_pkg;

  localparam int PROC_PC_W = 12;
  localparam int CTRL_W    = 11;
  localparam int IMM_W     = 17;
  localparam int TGT_W     = 27;

  // Control-word bit positions as emitted by the opcode decoder
  localparam int CTRL_BRLT    = 10;
  localparam int CTRL_ALUFUNC = 9;
  localparam int CTRL_RWD2    = 8;
  localparam int CTRL_RWE     = 7;
  localparam int CTRL_RSRC2   = 6;
  localparam int CTRL_ALUINB  = 5;
  localparam int CTRL_ALUOP   = 4;
  localparam int CTRL_DMWE    = 3;
  localparam int CTRL_RWD     = 2;
  localparam int CTRL_BRNE    = 1;
  localparam int CTRL_JP      = 0;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  typedef enum logic [0:0] {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } run_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_next_unit_if.sv
// ============================================================================
// pc_next_unit_if : decoder/ALU inputs and fetch-side outputs of the PC stage
// Revision 1.0
// ============================================================================
`default_nettype none

interface pc_next_unit_if
  import pc_next_unit_pkg::*;
#(
  parameter int PC_W  = PROC_PC_W,
  parameter int CNT_W = 32
);

  logic [CTRL_W-1:0] ctrl_sig;
  logic              alu_ne;
  logic              alu_lt;
  logic [IMM_W-1:0]  imm;
  logic [TGT_W-1:0]  target;
  logic              stall;

  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_plus1;
  logic [PC_W-1:0]   imem_addr;
  logic              instr_valid;
  logic              branch_taken;
  logic [CNT_W-1:0]  retired;

  modport master (
    output ctrl_sig, alu_ne, alu_lt, imm, target, stall,
    input  pc, pc_plus1, imem_addr, instr_valid, branch_taken, retired
  );

  modport slave (
    input  ctrl_sig, alu_ne, alu_lt, imm, target, stall,
    output pc, pc_plus1, imem_addr, instr_valid, branch_taken, retired
  );

endinterface

`default_nettype wire

// File: rtl/pc_next_unit_pc_adder.sv
// ============================================================================
// pc_adder : pc+1 and pc+1+sext(imm), both wrapped to PC_W bits
// Revision 1.0
// ============================================================================
`default_nettype none

module pc_adder
  import pc_next_unit_pkg::*;
#(
  parameter int PC_W = PROC_PC_W
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [IMM_W-1:0] imm,
  output logic [PC_W-1:0]  pc_plus1,
  output logic [PC_W-1:0]  pc_branch
);

  logic [PC_W-1:0] imm_ext;

  // Sign-extending then truncating to PC_W is the same as taking the low bits
  generate
    if (PC_W < IMM_W) begin : g_trunc
      logic unused_imm_hi;
      assign unused_imm_hi = ^imm[IMM_W-1:PC_W];
      assign imm_ext       = imm[PC_W-1:0];
    end else if (PC_W == IMM_W) begin : g_same
      assign imm_ext = imm;
    end else begin : g_sext
      assign imm_ext = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    end
  endgenerate

  assign pc_plus1  = PC_W'(pc + PC_W'(1));
  assign pc_branch = PC_W'(pc_plus1 + imm_ext);

endmodule

`default_nettype wire

// File: rtl/pc_next_unit.sv
// ============================================================================
// pc_next_unit : architectural PC, next-fetch address and retired counter
// Revision 1.0
// ============================================================================
`default_nettype none

module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter int PC_W  = PROC_PC_W,
  parameter int CNT_W = 32
) (
  input  logic          clock,
  input  logic          reset,
  pc_next_unit_if.slave bus
);

  run_state_t       state;
  run_state_t       state_nxt;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  next_pc;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  pc_br;
  logic [CNT_W-1:0] retired_q;
  logic             taken;
  logic             jump;
  logic             br_cond;
  logic             advance;
  logic             unused_ctrl;

  pc_adder #(.PC_W(PC_W)) u_pc_adder (
    .pc        (pc_q),
    .imm       (bus.imm),
    .pc_plus1  (pc_inc),
    .pc_branch (pc_br)
  );

  assign jump    = bus.ctrl_sig[CTRL_JP];
  assign br_cond = (bus.ctrl_sig[CTRL_BRNE] & bus.alu_ne)
                 | (bus.ctrl_sig[CTRL_BRLT] & bus.alu_lt);
  assign advance = (state == RUN) && !bus.stall;

  always_comb begin
    state_nxt = RUN;
    next_pc   = pc_q;
    taken     = 1'b0;
    case (state)
      // Fetch address 0 once more so the imem output matches pc on entry to RUN
      WARMUP: next_pc = '0;
      RUN: begin
        if (bus.stall) begin
          next_pc = pc_q;
        end else if (jump) begin
          next_pc = bus.target[PC_W-1:0];
          taken   = 1'b1;
        end else if (br_cond) begin
          next_pc = pc_br;
          taken   = 1'b1;
        end else begin
          next_pc = pc_inc;
        end
      end
      default: next_pc = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= WARMUP;
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= next_pc;
      if (advance) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus1     = pc_inc;
  assign bus.imem_addr    = next_pc;
  assign bus.instr_valid  = (state == RUN);
  assign bus.branch_taken = taken;
  assign bus.retired      = retired_q;

  assign unused_ctrl = ^{bus.ctrl_sig[CTRL_ALUFUNC:CTRL_RWD], bus.target[TGT_W-1:PC_W]};

endmodule

`default_nettype wire

// File: tb/tb_pc_next_unit.sv
// ============================================================================
// tb_pc_next_unit : directed vectors with a queue-based scoreboard monitor
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pc_next_unit;

  logic clock;
  logic reset;

  pc_next_unit_if #(.PC_W(12), .CNT_W(32)) bus ();

  pc_next_unit #(.PC_W(12), .CNT_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       nm;
    logic [11:0] pc;
    logic [11:0] pp;
    logic [11:0] ia;
    logic        iv;
    logic        bt;
    logic [31:0] ret;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  event async_ev;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s actual=%0h required=%0h", nm, f, act, req);
  endtask

  // Monitor: compares every queued expectation at the sampling point
  initial begin
    exp_t e;
    forever begin
      @(negedge clock or async_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "pc",           32'(bus.pc),           32'(e.pc));
        chk(e.nm, "pc_plus1",     32'(bus.pc_plus1),     32'(e.pp));
        chk(e.nm, "imem_addr",    32'(bus.imem_addr),    32'(e.ia));
        chk(e.nm, "instr_valid",  32'(bus.instr_valid),  32'(e.iv));
        chk(e.nm, "branch_taken", 32'(bus.branch_taken), 32'(e.bt));
        chk(e.nm, "retired",      bus.retired,           e.ret);
      end
    end
  end

  task automatic push(input string nm, input logic [11:0] epc, input logic [11:0] epp,
                      input logic [11:0] eia, input logic eiv, input logic ebt, input logic [31:0] eret);
    exp_t e;
    e.nm = nm; e.pc = epc; e.pp = epp; e.ia = eia; e.iv = eiv; e.bt = ebt; e.ret = eret;
    q.push_back(e);
  endtask

  task automatic drive(input logic [10:0] c, input logic ne, input logic lt,
                       input logic [16:0] im, input logic [26:0] tg, input logic st);
    bus.ctrl_sig = c; bus.alu_ne = ne; bus.alu_lt = lt;
    bus.imm = im; bus.target = tg; bus.stall = st;
  endtask

  // One cycle: apply inputs, queue the expected outputs, advance to next edge + 1
  task automatic cyc(input string nm, input logic [10:0] c, input logic ne, input logic lt,
                     input logic [16:0] im, input logic [26:0] tg, input logic st,
                     input logic [11:0] epc, input logic [11:0] epp, input logic [11:0] eia,
                     input logic eiv, input logic ebt, input logic [31:0] eret);
    drive(c, ne, lt, im, tg, st);
    push(nm, epc, epp, eia, eiv, ebt, eret);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(11'h000, 1'b0, 1'b0, 17'h0, 27'h0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    cyc("in_reset",  11'h000,0,0,17'h0,27'h0,0,      12'h000,12'h001,12'h000,0,0,32'd0);
    reset = 1'b0;
    cyc("warmup",    11'h000,0,0,17'h0,27'h0,0,      12'h000,12'h001,12'h000,0,0,32'd0);
    cyc("run_pc0",   11'h000,0,0,17'h0,27'h0,0,      12'h000,12'h001,12'h001,1,0,32'd0);
    cyc("run_pc1",   11'h000,0,0,17'h0,27'h0,0,      12'h001,12'h002,12'h002,1,0,32'd1);
    cyc("run_pc2",   11'h000,0,0,17'h0,27'h0,0,      12'h002,12'h003,12'h003,1,0,32'd2);
    cyc("run_pc3",   11'h000,0,0,17'h0,27'h0,0,      12'h003,12'h004,12'h004,1,0,32'd3);
    cyc("run_pc4",   11'h000,0,0,17'h0,27'h0,0,      12'h004,12'h005,12'h005,1,0,32'd4);
    cyc("jump_123",  11'h001,0,0,17'h0,27'h0000123,0,12'h005,12'h006,12'h123,1,1,32'd5);
    cyc("jump_00a",  11'h001,0,0,17'h0,27'h000000A,0,12'h123,12'h124,12'h00A,1,1,32'd6);
    cyc("bne_taken", 11'h052,1,0,17'h1FFFD,27'h0,0,  12'h00A,12'h00B,12'h008,1,1,32'd7);
    cyc("jump_back", 11'h001,0,0,17'h0,27'h000000A,0,12'h008,12'h009,12'h00A,1,1,32'd8);
    cyc("bne_not",   11'h052,0,0,17'h1FFFD,27'h0,0,  12'h00A,12'h00B,12'h00B,1,0,32'd9);
    cyc("jump_hi",   11'h001,0,0,17'h0,27'h7FFFFF0,0,12'h00B,12'h00C,12'hFF0,1,1,32'd10);
    cyc("blt_wrap",  11'h450,0,1,17'h0FFFF,27'h0,0,  12'hFF0,12'hFF1,12'hFF0,1,1,32'd11);
    cyc("jp_wins",   11'h403,1,1,17'h00005,27'h0000FFF,0,12'hFF0,12'hFF1,12'hFFF,1,1,32'd12);
    cyc("inc_wrap",  11'h000,0,0,17'h0,27'h0,0,      12'hFFF,12'h000,12'h000,1,0,32'd13);
    cyc("jump_7",    11'h001,0,0,17'h0,27'h0000007,0,12'h000,12'h001,12'h007,1,1,32'd14);
    cyc("stall_1",   11'h181,0,0,17'h0,27'h0000028,1,12'h007,12'h008,12'h007,1,0,32'd15);
    cyc("stall_2",   11'h181,0,0,17'h0,27'h0000028,1,12'h007,12'h008,12'h007,1,0,32'd15);
    cyc("stall_3",   11'h181,0,0,17'h0,27'h0000028,1,12'h007,12'h008,12'h007,1,0,32'd15);
    cyc("jal_go",    11'h181,0,0,17'h0,27'h0000028,0,12'h007,12'h008,12'h028,1,1,32'd15);
    cyc("bne_neg",   11'h052,1,0,17'h1FFC0,27'h0,0,  12'h028,12'h029,12'hFE9,1,1,32'd16);
    cyc("after_neg", 11'h000,0,0,17'h0,27'h0,0,      12'hFE9,12'hFEA,12'hFEA,1,0,32'd17);
    cyc("jump_2a",   11'h001,0,0,17'h0,27'h000002A,0,12'hFEA,12'hFEB,12'h02A,1,1,32'd18);

    // Asynchronous reset in the middle of the pc=2A cycle
    drive(11'h000, 1'b0, 1'b0, 17'h0, 27'h0, 1'b0);
    push("at_2a", 12'h02A, 12'h02B, 12'h02B, 1'b1, 1'b0, 32'd19);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    push("async_rst", 12'h000, 12'h001, 12'h000, 1'b0, 1'b0, 32'd0);
    -> async_ev;
    @(posedge clock);
    #1;
    cyc("rst_edge",  11'h000,0,0,17'h0,27'h0,0,      12'h000,12'h001,12'h000,0,0,32'd0);
    reset = 1'b0;
    cyc("warmup2",   11'h000,0,0,17'h0,27'h0,0,      12'h000,12'h001,12'h000,0,0,32'd0);
    cyc("run2_pc0",  11'h000,0,0,17'h0,27'h0,0,      12'h000,12'h001,12'h001,1,0,32'd0);
    cyc("run2_pc1",  11'h000,0,0,17'h0,27'h0,0,      12'h001,12'h002,12'h002,1,0,32'd1);

    @(negedge clock);
    #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain actual=%0d required=0 pending expectations", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
